// File: rtl/mem_stage_pkg.sv
// Shared types for the pipelined memory stage: op encoding and the
// two-cycle CALL/RET sequencer states.
package mem_stage_pkg;

  localparam int OP_W = 3;

  // Encoding 7 is reserved and decodes as NOP.
  typedef enum logic [OP_W-1:0] {
    NOP   = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    PUSH  = 3'd3,
    POP   = 3'd4,
    CALL  = 3'd5,
    RET   = 3'd6
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALL_LO = 2'd1,
    RET_LO  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_pipelined_stack_ctrl.sv
// Stack pointer and occupancy tracking for a downward-growing stack.
// SP always names the next free slot; sp_plus1 is the current top.
module stack_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        need_push,
  input  logic [1:0]        need_pop,
  input  logic              sp_dec,
  input  logic              sp_inc,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1,
  output logic              overflow,
  output logic              underflow
);

  localparam int             UW      = $clog2(STACK_DEPTH + 1);
  localparam logic [UW:0]    DEPTH_L = (UW+1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] sp_reg;
  logic [UW-1:0]     used_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_reg   <= '1;
      used_reg <= '0;
    end else if (sp_dec) begin
      sp_reg   <= sp_reg - ADDR_W'(1);
      used_reg <= used_reg + UW'(1);
    end else if (sp_inc) begin
      sp_reg   <= sp_reg + ADDR_W'(1);
      used_reg <= used_reg - UW'(1);
    end
  end

  assign sp       = sp_reg;
  assign sp_plus1 = sp_reg + ADDR_W'(1);

  // Checked against the whole op up front, so CALL/RET never split.
  assign overflow  = ({1'b0, used_reg} + (UW+1)'(need_push)) > DEPTH_L;
  assign underflow = used_reg < UW'(need_pop);

endmodule

// File: rtl/mem_stage_pipelined.sv
// Memory stage with data memory, downward stack and MEM/WB register;
// CALL/RET move a double-width PC as two stack words over two cycles.
module mem_stage_pipelined
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 256,
  parameter int SIDE_W      = 4,
  parameter int PC_W        = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [SIDE_W-1:0] side_in,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] rdata_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load_out,
  output logic [SIDE_W-1:0] side_out,
  output logic              stack_err,
  output logic [ADDR_W-1:0] sp_out
);

  if (PC_W != 2 * DATA_W || STACK_DEPTH < 2 || STACK_DEPTH > 2**ADDR_W - 1) begin : g_param_check
    $error("mem_stage_pipelined: illegal PC_W/STACK_DEPTH for the given DATA_W/ADDR_W");
  end

  logic [DATA_W-1:0] mem [2**ADDR_W];

  mem_state_t        state_reg, state_next;
  logic [DATA_W-1:0] pc_lo_reg, pc_lo_next, ret_lo_reg, ret_lo_next;
  logic [SIDE_W-1:0] side_hold_reg, side_hold_next;
  logic              out_valid_reg, out_valid_next, pc_load_reg, pc_load_next;
  logic              stack_err_reg, stack_err_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [PC_W-1:0]   pc_out_reg, pc_out_next;
  logic [SIDE_W-1:0] side_out_reg, side_out_next;

  logic              mem_we, stall_c, sp_dec, sp_inc, overflow, underflow;
  logic [ADDR_W-1:0] mem_waddr, rd_addr, sp, sp_plus1;
  logic [DATA_W-1:0] mem_wdata, rd_data;
  logic [1:0]        need_push, need_pop;
  mem_op_t           op_dec;
  logic              unused_addr_hi;

  assign op_dec         = mem_op_t'(op);
  assign rd_data        = mem[rd_addr];
  assign unused_addr_hi = ^addr_in[DATA_W-1:ADDR_W];

  stack_ctrl #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack_ctrl (
    .clk       (clk),
    .reset     (reset),
    .need_push (need_push),
    .need_pop  (need_pop),
    .sp_dec    (sp_dec),
    .sp_inc    (sp_inc),
    .sp        (sp),
    .sp_plus1  (sp_plus1),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_comb begin
    state_next     = state_reg;
    pc_lo_next     = pc_lo_reg;
    ret_lo_next    = ret_lo_reg;
    side_hold_next = side_hold_reg;
    out_valid_next = 1'b0;
    rdata_next     = '0;
    pc_out_next    = '0;
    pc_load_next   = 1'b0;
    side_out_next  = side_out_reg;
    stack_err_next = stack_err_reg;
    mem_we         = 1'b0;
    mem_waddr      = sp;
    mem_wdata      = wdata_in;
    rd_addr        = sp_plus1;
    need_push      = 2'd0;
    need_pop       = 2'd0;
    sp_dec         = 1'b0;
    sp_inc         = 1'b0;
    stall_c        = 1'b0;
    case (state_reg)
      IDLE: if (in_valid) begin
        out_valid_next = 1'b1;
        side_out_next  = side_in;
        case (op_dec)
          LOAD: begin
            rd_addr    = addr_in[ADDR_W-1:0];
            rdata_next = rd_data;
          end
          STORE: begin
            mem_we    = 1'b1;
            mem_waddr = addr_in[ADDR_W-1:0];
          end
          PUSH: begin
            need_push = 2'd1;
            if (overflow) stack_err_next = 1'b1;
            else begin
              mem_we = 1'b1;
              sp_dec = 1'b1;
            end
          end
          POP: begin
            need_pop = 2'd1;
            if (underflow) stack_err_next = 1'b1;
            else begin
              sp_inc     = 1'b1;
              rdata_next = rd_data;
            end
          end
          // A suppressed CALL/RET completes in one cycle, so it must not stall.
          CALL: begin
            need_push = 2'd2;
            if (overflow) stack_err_next = 1'b1;
            else begin
              stall_c        = 1'b1;
              mem_we         = 1'b1;
              mem_wdata      = pc_in[PC_W-1:DATA_W];
              sp_dec         = 1'b1;
              pc_lo_next     = pc_in[DATA_W-1:0];
              side_hold_next = side_in;
              side_out_next  = side_out_reg;
              out_valid_next = 1'b0;
              state_next     = CALL_LO;
            end
          end
          RET: begin
            need_pop = 2'd2;
            if (underflow) stack_err_next = 1'b1;
            else begin
              stall_c        = 1'b1;
              sp_inc         = 1'b1;
              ret_lo_next    = rd_data;
              side_hold_next = side_in;
              side_out_next  = side_out_reg;
              out_valid_next = 1'b0;
              state_next     = RET_LO;
            end
          end
          default: ;
        endcase
      end
      CALL_LO: begin
        mem_we         = 1'b1;
        mem_wdata      = pc_lo_reg;
        sp_dec         = 1'b1;
        out_valid_next = 1'b1;
        side_out_next  = side_hold_reg;
        state_next     = IDLE;
      end
      RET_LO: begin
        sp_inc         = 1'b1;
        pc_out_next    = {rd_data, ret_lo_reg};
        pc_load_next   = 1'b1;
        out_valid_next = 1'b1;
        side_out_next  = side_hold_reg;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes are blocked while reset is held so a reset mid-CALL stops cleanly.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_lo_reg     <= '0;
      ret_lo_reg    <= '0;
      side_hold_reg <= '0;
      out_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      pc_out_reg    <= '0;
      pc_load_reg   <= 1'b0;
      side_out_reg  <= '0;
      stack_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_lo_reg     <= pc_lo_next;
      ret_lo_reg    <= ret_lo_next;
      side_hold_reg <= side_hold_next;
      out_valid_reg <= out_valid_next;
      rdata_reg     <= rdata_next;
      pc_out_reg    <= pc_out_next;
      pc_load_reg   <= pc_load_next;
      side_out_reg  <= side_out_next;
      stack_err_reg <= stack_err_next;
    end
  end

  assign stall       = stall_c & ~reset;
  assign out_valid   = out_valid_reg;
  assign rdata_out   = rdata_reg;
  assign pc_out      = pc_out_reg;
  assign pc_load_out = pc_load_reg;
  assign side_out    = side_out_reg;
  assign stack_err   = stack_err_reg;
  assign sp_out      = sp;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Directed self-checking bench for mem_stage_pipelined: inputs change and
// outputs are sampled on the falling edge, away from the active edge.
module tb_mem_stage_pipelined;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] addr_in = '0, wdata_in = '0;
  logic [31:0] pc_in = '0;
  logic [3:0]  side_in = '0;
  logic        stall, out_valid, pc_load_out, stack_err;
  logic [15:0] rdata_out;
  logic [31:0] pc_out;
  logic [3:0]  side_out;
  logic [10:0] sp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_pipelined #(
    .DATA_W(16), .ADDR_W(11), .STACK_DEPTH(256), .SIDE_W(4), .PC_W(32)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
    .addr_in(addr_in), .wdata_in(wdata_in), .pc_in(pc_in), .side_in(side_in),
    .stall(stall), .out_valid(out_valid), .rdata_out(rdata_out),
    .pc_out(pc_out), .pc_load_out(pc_load_out), .side_out(side_out),
    .stack_err(stack_err), .sp_out(sp_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input mem_op_t o, input logic [15:0] a,
                       input logic [15:0] d, input logic [31:0] pc, input logic [3:0] s);
    in_valid = v;
    op       = o;
    addr_in  = a;
    wdata_in = d;
    pc_in    = pc;
    side_in  = s;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_sp", sp_out, 11'h7FF);
    check("rst_err", stack_err, 0);
    check("rst_pcload", pc_load_out, 0);
    reset = 1'b0;

    // STORE then LOAD
    drive(1, STORE, 16'h0010, 16'hBEEF, 0, 4'h1); step();
    check("store_valid", out_valid, 1);
    check("store_rdata", rdata_out, 0);
    check("store_side", side_out, 4'h1);
    drive(1, LOAD, 16'h0010, 0, 0, 4'h2); step();
    check("load_valid", out_valid, 1);
    check("load_rdata", rdata_out, 16'hBEEF);
    check("load_side", side_out, 4'h2);
    drive(0, NOP, 0, 0, 0, 0); step();
    check("idle_valid", out_valid, 0);

    // PUSH/PUSH/POP/POP
    drive(1, PUSH, 0, 16'h1111, 0, 0); step();
    check("push1_sp", sp_out, 11'h7FE);
    drive(1, PUSH, 0, 16'h2222, 0, 0); step();
    check("push2_sp", sp_out, 11'h7FD);
    drive(1, POP, 0, 0, 0, 0); step();
    check("pop1_rdata", rdata_out, 16'h2222);
    check("pop1_valid", out_valid, 1);
    drive(1, POP, 0, 0, 0, 0); step();
    check("pop2_rdata", rdata_out, 16'h1111);
    check("pop2_sp", sp_out, 11'h7FF);
    check("pop2_err", stack_err, 0);

    // CALL then RET
    drive(1, CALL, 0, 0, 32'h0001_2345, 4'h5); #1;
    check("call_stall", stall, 1);
    step();
    check("call_bubble", out_valid, 0);
    check("call_lo_stall", stall, 0);
    check("call_mid_sp", sp_out, 11'h7FE);
    step();
    check("call_valid", out_valid, 1);
    check("call_side", side_out, 4'h5);
    check("call_sp", sp_out, 11'h7FD);
    check("call_pcload", pc_load_out, 0);
    drive(1, RET, 0, 0, 0, 4'h6); #1;
    check("ret_stall", stall, 1);
    step();
    check("ret_bubble", out_valid, 0);
    check("ret_bubble_pcload", pc_load_out, 0);
    check("ret_bubble_side", side_out, 4'h5);
    step();
    check("ret_valid", out_valid, 1);
    check("ret_pc", pc_out, 32'h0001_2345);
    check("ret_pcload", pc_load_out, 1);
    check("ret_side", side_out, 4'h6);
    check("ret_sp", sp_out, 11'h7FF);
    drive(1, NOP, 0, 0, 0, 0); step();
    check("nop_pcload", pc_load_out, 0);
    check("nop_valid", out_valid, 1);

    // Underflow
    drive(1, POP, 0, 0, 0, 0); step();
    check("uf_err", stack_err, 1);
    check("uf_rdata", rdata_out, 0);
    check("uf_sp", sp_out, 11'h7FF);
    check("uf_valid", out_valid, 1);
    drive(1, RET, 0, 0, 0, 0); #1;
    check("uf_ret_stall", stall, 0);
    step();
    check("uf_ret_valid", out_valid, 1);
    check("uf_ret_pcload", pc_load_out, 0);
    check("uf_ret_pc", pc_out, 0);
    drive(1, PUSH, 0, 16'hABCD, 0, 0); step();
    drive(1, POP, 0, 0, 0, 0); step();
    check("post_uf_pop", rdata_out, 16'hABCD);
    check("post_uf_sp", sp_out, 11'h7FF);
    check("sticky_err", stack_err, 1);

    // Overflow
    drive(0, NOP, 0, 0, 0, 0);
    sync_reset();
    check("rst2_err", stack_err, 0);
    for (int i = 0; i < 256; i++) begin
      drive(1, PUSH, 0, 16'(16'h1000 + i), 0, 0);
      step();
    end
    check("full_sp", sp_out, 11'h6FF);
    check("full_err", stack_err, 0);
    drive(1, PUSH, 0, 16'hDEAD, 0, 0); step();
    check("of_err", stack_err, 1);
    check("of_sp", sp_out, 11'h6FF);
    check("of_valid", out_valid, 1);
    drive(1, POP, 0, 0, 0, 0); step();
    check("of_pop_rdata", rdata_out, 16'h10FF);
    check("of_pop_sp", sp_out, 11'h700);
    drive(1, CALL, 0, 0, 32'hCAFE_F00D, 4'h3); #1;
    check("of_call_stall", stall, 0);
    step();
    check("of_call_valid", out_valid, 1);
    check("of_call_sp", sp_out, 11'h700);
    check("of_call_pcload", pc_load_out, 0);
    drive(1, POP, 0, 0, 0, 0); step();
    check("of_call_nowrite", rdata_out, 16'h10FE);
    check("of_call_sp2", sp_out, 11'h701);

    // Async reset while in CALL_LO
    drive(0, NOP, 0, 0, 0, 0);
    sync_reset();
    drive(1, NOP, 0, 0, 0, 4'hF); step();
    drive(1, CALL, 0, 0, 32'hDEAD_BEEF, 4'h7); step();
    check("pre_rst_sp", sp_out, 11'h7FE);
    check("pre_rst_side", side_out, 4'hF);
    #2 reset = 1'b1;
    #1;
    check("arst_side", side_out, 0);
    check("arst_sp", sp_out, 11'h7FF);
    check("arst_valid", out_valid, 0);
    check("arst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, CALL, 0, 0, 32'h0000_0042, 4'h1); #1;
    check("arst_idle_stall", stall, 1);
    step();
    check("arst_call_bubble", out_valid, 0);
    drive(0, NOP, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
